// File: rtl/vending_controller_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_controller_multi
// Description : Multi-item vending FSM covering credit, per-item stock,
//               optional scarcity pricing and a coin-by-coin refund dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_controller_multi #(
    parameter int                           NUM_ITEMS  = 4,
    parameter int                           CREDIT_W   = 8,
    parameter int                           MAX_CREDIT = 99,
    parameter int                           STOCK_W    = 4,
    parameter int                           INIT_STOCK = 5,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = {8'd5, 8'd6, 8'd4, 8'd3},
    parameter bit                           DYN_PRICE  = 1'b0,
    parameter int                           SURCHARGE  = 1,
    parameter int                           LOW_STOCK  = 2,
    localparam int                          IW         = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coin_valid,
    input  logic [2:0]           coin_value,
    input  logic                 purchase_req,
    input  logic                 cancel_req,
    input  logic [IW-1:0]        item_sel,
    input  logic                 restock,
    output logic [CREDIT_W-1:0]  credit,
    output logic [CREDIT_W-1:0]  price,
    output logic [STOCK_W-1:0]   stock_level,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 vend_pulse,
    output logic [IW-1:0]        vend_item,
    output logic                 coin_reject,
    output logic                 change_coin_valid,
    output logic [2:0]           change_coin_value,
    output logic [CREDIT_W-1:0]  change_due,
    output logic                 error_flag,
    output logic [1:0]           error_code,
    output logic                 busy,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_VEND   = 3'd2,
        S_REFUND = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [CREDIT_W:0]   c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  c_init_stock = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0]  c_low_stock  = STOCK_W'(LOW_STOCK);
    localparam logic [CREDIT_W-1:0] c_surcharge  = CREDIT_W'(SURCHARGE);

    state_t               r_state;
    logic [CREDIT_W-1:0]  r_credit;
    logic [CREDIT_W-1:0]  r_change_due;
    logic [1:0]           r_error_code;
    logic [IW-1:0]        r_vend_item;
    logic                 r_vend_pulse;
    logic                 r_error_flag;
    logic                 r_coin_reject;
    logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];

    logic [STOCK_W-1:0]   w_sel_stock;
    logic [CREDIT_W-1:0]  w_sel_price;
    logic [STOCK_W-1:0]   w_vi_stock;
    logic [CREDIT_W-1:0]  w_vi_price;
    logic                 w_change_coin_valid;
    logic [2:0]           w_change_coin_value;
    logic [CREDIT_W-1:0]  w_change_amount;
    logic [CREDIT_W-1:0]  w_credit_base;
    logic [CREDIT_W:0]    w_coin_sum;
    logic                 w_coin_legal;
    logic                 w_coin_accept;
    logic                 w_coin_reject;
    logic [CREDIT_W-1:0]  w_credit_next;

    // Scarcity surcharge applies only to stocked items at or below the threshold.
    function automatic logic [CREDIT_W-1:0] f_price(input int idx, input logic [STOCK_W-1:0] stk);
        logic [CREDIT_W-1:0] p;
        p = PRICES[CREDIT_W*idx +: CREDIT_W];
        if (DYN_PRICE && (stk != '0) && (stk <= c_low_stock)) begin
            p = p + c_surcharge;
        end
        return p;
    endfunction

    always_comb begin
        w_sel_stock = '0;
        w_sel_price = '0;
        w_vi_stock  = '0;
        w_vi_price  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel == IW'(i)) begin
                w_sel_stock = r_stock[i];
                w_sel_price = f_price(i, r_stock[i]);
            end
            if (r_vend_item == IW'(i)) begin
                w_vi_stock = r_stock[i];
                w_vi_price = f_price(i, r_stock[i]);
            end
        end
    end

    always_comb begin
        w_change_coin_value = 3'd0;
        if (r_change_due >= CREDIT_W'(5)) begin
            w_change_coin_value = 3'd5;
        end else if (r_change_due >= CREDIT_W'(2)) begin
            w_change_coin_value = 3'd2;
        end else if (r_change_due != '0) begin
            w_change_coin_value = 3'd1;
        end
        w_change_coin_valid = (r_state == S_REFUND) && (r_change_due != '0);
        w_change_amount     = w_change_coin_valid ? CREDIT_W'(w_change_coin_value) : '0;
    end

    // The ceiling check sees credit after this cycle's vend charge or refund coin.
    always_comb begin
        w_credit_base = r_credit;
        case (r_state)
            S_VEND:   w_credit_base = r_credit - w_vi_price;
            S_REFUND: w_credit_base = r_credit - w_change_amount;
            default:  w_credit_base = r_credit;
        endcase
        w_coin_legal  = (coin_value == 3'd1) || (coin_value == 3'd2) || (coin_value == 3'd5);
        w_coin_sum    = {1'b0, w_credit_base} + (CREDIT_W+1)'(coin_value);
        w_coin_accept = coin_valid && (r_state != S_REFUND) && w_coin_legal &&
                        (w_coin_sum <= c_max_credit);
        w_coin_reject = coin_valid && !w_coin_accept;
        w_credit_next = w_coin_accept ? w_coin_sum[CREDIT_W-1:0] : w_credit_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_change_due  <= '0;
            r_error_code  <= 2'd0;
            r_vend_item   <= '0;
            r_vend_pulse  <= 1'b0;
            r_error_flag  <= 1'b0;
            r_coin_reject <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= c_init_stock;
            end
        end else begin
            r_credit      <= w_credit_next;
            r_coin_reject <= w_coin_reject;
            r_vend_pulse  <= 1'b0;
            r_error_flag  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cancel_req) begin
                        // Refund whatever credit will stand after this edge, including a coin arriving now.
                        r_change_due <= w_credit_next;
                        r_state      <= S_REFUND;
                    end else if (purchase_req) begin
                        r_vend_item <= item_sel;
                        r_state     <= S_CHECK;
                    end else if (restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            if (item_sel == IW'(i)) begin
                                r_stock[i] <= c_init_stock;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_vi_stock == '0) begin
                        r_error_code <= 2'd2;
                        r_error_flag <= 1'b1;
                        r_state      <= S_ERROR;
                    end else if (r_credit < w_vi_price) begin
                        r_error_code <= 2'd1;
                        r_error_flag <= 1'b1;
                        r_state      <= S_ERROR;
                    end else begin
                        r_error_code <= 2'd0;
                        r_vend_pulse <= 1'b1;
                        r_state      <= S_VEND;
                    end
                end
                S_VEND: begin
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (r_vend_item == IW'(i)) begin
                            r_stock[i] <= r_stock[i] - STOCK_W'(1);
                        end
                    end
                    r_state <= S_IDLE;
                end
                S_REFUND: begin
                    if (r_change_due == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_change_due <= r_change_due - w_change_amount;
                    end
                end
                S_ERROR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_sold_out
        assign sold_out[g] = (r_stock[g] == '0);
    end

    assign credit            = r_credit;
    assign price             = w_sel_price;
    assign stock_level       = w_sel_stock;
    assign vend_pulse        = r_vend_pulse;
    assign vend_item         = r_vend_item;
    assign coin_reject       = r_coin_reject;
    assign change_coin_valid = w_change_coin_valid;
    assign change_coin_value = w_change_coin_value;
    assign change_due        = r_change_due;
    assign error_flag        = r_error_flag;
    assign error_code        = r_error_code;
    assign busy              = (r_state != S_IDLE);
    assign state             = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_controller_multi
// Description : Directed table-driven bench for vending_controller_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_controller_multi;

    logic       clk = 1'b0;
    logic       rst_n, coin_valid, purchase_req, cancel_req, restock;
    logic [2:0] coin_value;
    logic [1:0] item_sel;

    logic [7:0] credit, price, change_due;
    logic [3:0] stock_level, sold_out;
    logic       vend_pulse, coin_reject, change_coin_valid, error_flag, busy;
    logic [1:0] vend_item, error_code;
    logic [2:0] change_coin_value, state;

    logic [7:0] d_credit, d_price, d_change_due;
    logic [3:0] d_stock_level, d_sold_out;
    logic       d_vend_pulse, d_coin_reject, d_change_coin_valid, d_error_flag, d_busy;
    logic [1:0] d_vend_item, d_error_code;
    logic [2:0] d_change_coin_value, d_state;

    always #5 clk = ~clk;

    vending_controller_multi dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .purchase_req(purchase_req), .cancel_req(cancel_req), .item_sel(item_sel),
        .restock(restock), .credit(credit), .price(price), .stock_level(stock_level),
        .sold_out(sold_out), .vend_pulse(vend_pulse), .vend_item(vend_item),
        .coin_reject(coin_reject), .change_coin_valid(change_coin_valid),
        .change_coin_value(change_coin_value), .change_due(change_due),
        .error_flag(error_flag), .error_code(error_code), .busy(busy), .state(state)
    );

    vending_controller_multi #(.DYN_PRICE(1'b1)) dut_dyn (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .purchase_req(purchase_req), .cancel_req(cancel_req), .item_sel(item_sel),
        .restock(restock), .credit(d_credit), .price(d_price), .stock_level(d_stock_level),
        .sold_out(d_sold_out), .vend_pulse(d_vend_pulse), .vend_item(d_vend_item),
        .coin_reject(d_coin_reject), .change_coin_valid(d_change_coin_valid),
        .change_coin_value(d_change_coin_value), .change_due(d_change_due),
        .error_flag(d_error_flag), .error_code(d_error_code), .busy(d_busy), .state(d_state)
    );

    typedef struct {
        bit cv; int val; bit pur; bit can; int sel;
        int credit; int st; bit vend; bit rej; bit eflag; int ecode; int stk; int prc;
    } vec_t;

    vec_t vecs[17];
    int   checks = 0;
    int   errors = 0;
    bit   done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid   = 1'b0;
        coin_value   = 3'd0;
        purchase_req = 1'b0;
        cancel_req   = 1'b0;
        restock      = 1'b0;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_value = 3'(v);
        tick();
    endtask

    task automatic buy(input int sel);
        item_sel     = 2'(sel);
        purchase_req = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        // cv val pur can sel | credit state vend rej eflag ecode stock price
        vecs[0]  = '{1, 5, 0, 0, 0,  5, 0, 0, 0, 0, 0, 5, 3};
        vecs[1]  = '{0, 0, 1, 0, 0,  5, 1, 0, 0, 0, 0, 5, 3};
        vecs[2]  = '{0, 0, 0, 0, 0,  5, 2, 1, 0, 0, 0, 5, 3};
        vecs[3]  = '{0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 4, 3};
        vecs[4]  = '{0, 0, 1, 0, 2,  2, 1, 0, 0, 0, 0, 5, 6};
        vecs[5]  = '{0, 0, 0, 0, 2,  2, 5, 0, 0, 1, 1, 5, 6};
        vecs[6]  = '{0, 0, 0, 0, 2,  2, 0, 0, 0, 0, 1, 5, 6};
        vecs[7]  = '{1, 5, 0, 0, 0,  7, 0, 0, 0, 0, 1, 4, 3};
        vecs[8]  = '{0, 0, 1, 0, 0,  7, 1, 0, 0, 0, 1, 4, 3};
        vecs[9]  = '{0, 0, 0, 0, 0,  7, 2, 1, 0, 0, 0, 4, 3};
        vecs[10] = '{1, 2, 0, 0, 0,  6, 0, 0, 0, 0, 0, 3, 3};
        vecs[11] = '{1, 3, 0, 0, 0,  6, 0, 0, 1, 0, 0, 3, 3};
        vecs[12] = '{0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0, 3, 3};
        vecs[13] = '{0, 0, 1, 1, 0,  6, 4, 0, 0, 0, 0, 3, 3};
        vecs[14] = '{0, 0, 1, 0, 0,  1, 4, 0, 0, 0, 0, 3, 3};
        vecs[15] = '{0, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0, 3, 3};
        vecs[16] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 3};

        rst_n = 1'b0; coin_valid = 1'b0; coin_value = 3'd0; purchase_req = 1'b0;
        cancel_req = 1'b0; restock = 1'b0; item_sel = 2'd0;
        #12;
        chk("reset credit", credit, 0);
        chk("reset state", state, 0);
        chk("reset stock", stock_level, 5);
        chk("reset sold_out", sold_out, 0);
        chk("reset busy", busy, 0);
        chk("reset error_code", error_code, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            coin_valid   = vecs[i].cv;
            coin_value   = 3'(vecs[i].val);
            purchase_req = vecs[i].pur;
            cancel_req   = vecs[i].can;
            item_sel     = 2'(vecs[i].sel);
            tick();
            chk($sformatf("v%0d credit", i), credit, vecs[i].credit);
            chk($sformatf("v%0d state", i), state, vecs[i].st);
            chk($sformatf("v%0d vend_pulse", i), vend_pulse, vecs[i].vend);
            chk($sformatf("v%0d coin_reject", i), coin_reject, vecs[i].rej);
            chk($sformatf("v%0d error_flag", i), error_flag, vecs[i].eflag);
            chk($sformatf("v%0d error_code", i), error_code, vecs[i].ecode);
            chk($sformatf("v%0d stock_level", i), stock_level, vecs[i].stk);
            chk($sformatf("v%0d price", i), price, vecs[i].prc);
            if (i == 2) chk("vend_item", vend_item, 0);
        end

        // Refund of 8 with a coin refused mid-refund
        coin(5); coin(2); coin(1);
        chk("t3 credit", credit, 8);
        cancel_req = 1'b1; tick();
        chk("t3 r0 state", state, 4);
        chk("t3 r0 due", change_due, 8);
        chk("t3 r0 cvalid", change_coin_valid, 1);
        chk("t3 r0 cval", change_coin_value, 5);
        coin(1);
        chk("t3 r1 due", change_due, 3);
        chk("t3 r1 cval", change_coin_value, 2);
        chk("t3 r1 credit", credit, 3);
        chk("t3 r1 reject", coin_reject, 1);
        tick();
        chk("t3 r2 due", change_due, 1);
        chk("t3 r2 cval", change_coin_value, 1);
        tick();
        chk("t3 r3 due", change_due, 0);
        chk("t3 r3 cvalid", change_coin_valid, 0);
        chk("t3 r3 credit", credit, 0);
        tick();
        chk("t3 idle", state, 0);

        // Sell out item 1, then restock it
        for (int k = 0; k < 5; k++) coin(5);
        for (int k = 0; k < 5; k++) buy(1);
        chk("t4 credit", credit, 5);
        chk("t4 sold_out1", sold_out[1], 1);
        chk("t4 stock", stock_level, 0);
        purchase_req = 1'b1; tick(); tick();
        chk("t4 err state", state, 5);
        chk("t4 err code", error_code, 2);
        tick();
        chk("t4 credit kept", credit, 5);
        restock = 1'b1; tick();
        chk("t4 restock stock", stock_level, 5);
        chk("t4 restock sold_out1", sold_out[1], 0);

        // Credit ceiling
        for (int k = 0; k < 18; k++) coin(5);
        coin(2);
        chk("t5 credit97", credit, 97);
        coin(5);
        chk("t5 over reject", coin_reject, 1);
        chk("t5 over credit", credit, 97);
        coin(2);
        chk("t5 credit99", credit, 99);
        chk("t5 accept", coin_reject, 0);
        coin(3);
        chk("t5 invalid reject", coin_reject, 1);
        chk("t5 invalid credit", credit, 99);
        cancel_req = 1'b1; tick();
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (state == 3'd0) done = 1'b1;
            else tick();
        end
        chk("t5 drain done", done, 1);
        chk("t5 drain credit", credit, 0);

        // Asynchronous reset in the middle of a refund
        item_sel = 2'd0;
        coin(5);
        cancel_req = 1'b1; tick();
        chk("t6 refund cvalid", change_coin_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst credit", credit, 0);
        chk("t6 rst cvalid", change_coin_valid, 0);
        chk("t6 rst state", state, 0);
        chk("t6 rst stock0", stock_level, 5);
        chk("t6 rst sold_out", sold_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scarcity pricing on the DYN_PRICE instance
        chk("t6 dyn price s5", d_price, 3);
        coin(5); coin(5);
        buy(0); buy(0);
        chk("t6 dyn stock3", d_stock_level, 3);
        chk("t6 dyn price s3", d_price, 3);
        buy(0);
        chk("t6 dyn stock2", d_stock_level, 2);
        chk("t6 dyn price s2", d_price, 4);
        chk("t6 static price s2", price, 3);
        chk("t6 dyn credit", d_credit, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
